reg_estagio_elastico: RTL and testbench

- Parametrised successor to the plain 32-bit pipeline stage register.
- Adds valid/ready handshake, a full-throughput 2-entry skid buffer (stall without losing data or throughput), synchronous flush and synchronous reset.
- Sits between datapath pipeline stages so a downstream stall propagates upstream one cycle later, through a registered inp_ready.

---
 rtl/reg_estagio_elastico.sv | 81 ++++++++
 tb/tb_reg_estagio_elastico.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_estagio_elastico.sv
// reg_estagio_elastico: elastic pipeline stage with a 2-entry skid buffer, valid/ready handshake and sync flush.
// Defining REG_ESTAGIO_STALL_CNT_EN adds a saturating stall_cnt output.
module reg_estagio_elastico #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic [WIDTH-1:0] inp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef REG_ESTAGIO_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             acc;

    // inp_ready comes only from registered state, so stalls reach upstream one cycle late
    assign inp_ready = (state_q != SKID) && !rst;
    assign out_valid = state_q != EMPTY;
    assign out       = main_q;
    assign acc       = inp_valid && inp_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) state_d = EMPTY;
        else begin
            case (state_q)
                EMPTY: if (acc) begin
                    main_d  = inp;
                    state_d = FULL;
                end
                FULL: if (acc && out_ready) main_d = inp;
                else if (acc) begin
                    skid_d  = inp;
                    state_d = SKID;
                end
                else if (out_ready) state_d = EMPTY;
                SKID: if (out_ready) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef REG_ESTAGIO_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
`endif
endmodule

// File: tb/tb_reg_estagio_elastico.sv
// tb_reg_estagio_elastico: directed and randomized checks of reg_estagio_elastico against a queue model.
module tb_reg_estagio_elastico;
    localparam int W = 32;
    localparam int CW = 3;

    logic          clk = 0;
    logic          rst = 1, flush = 0, inp_valid = 0, out_ready = 0;
    logic [W-1:0]  inp = '0;
    logic          inp_ready, out_valid;
    logic [W-1:0]  out;
`ifdef REG_ESTAGIO_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int total = 0, bad = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_out = '0;
    int           exp_cnt = 0;

    reg_estagio_elastico #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inp_valid(inp_valid), .inp_ready(inp_ready), .inp(inp),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef REG_ESTAGIO_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic m_ready();
        return q.size() < 2 && !rst;
    endfunction

    // one clock: model moves on the same edge as the DUT, then outputs settle for sampling
    task automatic tick();
        logic ov, ir;
        ov = m_valid();
        ir = m_ready();
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_out = '0;
            exp_cnt = 0;
        end else begin
            if (ov && !out_ready && exp_cnt < (1 << CW) - 1) exp_cnt++;
            if (flush) q.delete();
            else begin
                if (ov && out_ready) void'(q.pop_front());
                if (inp_valid && ir) q.push_back(inp);
            end
            if (q.size() > 0) exp_out = q[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; inp_valid = 1; inp = 32'h55555555; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
            total++; if (inp_ready !== 1'b0) begin bad++; $display("FAIL reset_inp_ready got=%b exp=0", inp_ready); end
        end
        rst = 0; inp_valid = 0;
        #1;
        total++; if (inp_ready !== 1'b1) begin bad++; $display("FAIL release_inp_ready got=%b exp=1", inp_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            inp = W'(i); inp_valid = 1;
            tick();
            total++; if (out !== W'(i) || out_valid !== 1'b1) begin bad++; $display("FAIL stream_word%0d got=%h/%b exp=%h/1", i, out, out_valid, i); end
            total++; if (inp_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b exp=1", i, inp_ready); end
        end
        inp_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0 || out !== 32'h8) begin bad++; $display("FAIL stream_drain got=%h/%b exp=00000008/0", out, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1; inp_valid = 1; inp = 32'hAAAAAAAA;
        tick();
        inp = 32'hBBBBBBBB; out_ready = 0;
        tick();
        inp_valid = 0;
        total++; if (out !== 32'hAAAAAAAA || inp_ready !== 1'b0) begin bad++; $display("FAIL bp_skid got=%h ready=%b exp=aaaaaaaa ready=0", out, inp_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (out !== 32'hAAAAAAAA || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%h/%b exp=aaaaaaaa/1", i, out, out_valid); end
        end
        out_ready = 1;
        tick();
        total++; if (out !== 32'hBBBBBBBB || out_valid !== 1'b1 || inp_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b ready=%b exp=bbbbbbbb/1 ready=1", out, out_valid, inp_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_skid();
        out_ready = 1; inp_valid = 1; inp = 32'hAAAAAAAA;
        tick();
        out_ready = 0; inp = 32'hBBBBBBBB;
        tick();
        inp = 32'hCCCCCCCC; flush = 1;
        tick();
        flush = 0;
        total++; if (out_valid !== 1'b0 || inp_ready !== 1'b1 || out !== 32'hAAAAAAAA) begin bad++; $display("FAIL flush_skid got=%h/%b ready=%b exp=aaaaaaaa/0 ready=1", out, out_valid, inp_ready); end
        inp_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || out === 32'hCCCCCCCC) begin bad++; $display("FAIL flush_no_c got=%h/%b exp=aaaaaaaa/0", out, out_valid); end
        end
    endtask

    task automatic test_rst_flush();
        out_ready = 0; inp_valid = 1; inp = 32'h12345678;
        tick();
        rst = 1; flush = 1;
        tick();
        total++; if (out !== 32'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_flush got=%h/%b exp=00000000/0", out, out_valid); end
        rst = 0;
        inp = 32'h9ABCDEF0;
        tick();
        total++; if (out_valid !== 1'b0 || out !== 32'h0) begin bad++; $display("FAIL flush_empty got=%h/%b exp=00000000/0", out, out_valid); end
        flush = 0; inp_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_hold got=%b exp=0", out_valid); end
    endtask

`ifdef REG_ESTAGIO_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1; tick(); rst = 0;
        out_ready = 0; inp_valid = 1; inp = 32'h0BADF00D;
        tick();
        inp_valid = 0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (stall_cnt !== 3'd7) begin bad++; $display("FAIL stall_sat got=%0d exp=7", stall_cnt); end
        flush = 1; tick(); flush = 0;
        total++; if (stall_cnt !== 3'd7) begin bad++; $display("FAIL stall_flush got=%0d exp=7", stall_cnt); end
        rst = 1; tick(); rst = 0;
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL stall_rst got=%0d exp=0", stall_cnt); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            inp_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            inp = W'($urandom);
            flush = 1'($urandom_range(0, 15) == 0);
            rst = 1'($urandom_range(0, 63) == 0);
            tick();
            total++;
            if (out_valid !== m_valid() || inp_ready !== m_ready() || out !== exp_out) begin
                bad++;
                $display("FAIL random%0d got=%h/%b ready=%b exp=%h/%b ready=%b", i, out, out_valid, inp_ready, exp_out, m_valid(), m_ready());
            end
`ifdef REG_ESTAGIO_STALL_CNT_EN
            total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL random_cnt%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
`endif
        end
        rst = 0; flush = 0; inp_valid = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_skid();
        test_rst_flush();
`ifdef REG_ESTAGIO_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
